projectile_sequencer: RTL and testbench

Frame-rate trajectory controller for the thrown projectile. It accepts a throw request carrying launch position and velocity and advances the projectile once per video frame under constant gravity. It outputs an absolute `x_pos`/`y_pos` (0 = screen centre / ground) plus a visibility flag, which feed the projectile draw stage in the VGA pipeline. The frame tick is derived internally from `vsync`.

---
 rtl/projectile_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_projectile_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/projectile_sequencer.sv
// Frame-rate projectile trajectory controller.
// Accepts a throw (launch x, vx, vy), then steps position once per video frame
// (rising edge of vsync) under constant gravity until the projectile hits the
// ground or leaves the horizontal bounds, then holds it visible for a while.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   vsync           VGA vertical sync; its rising edge is the frame tick
//   throw_req       launch request, sampled only while throw_ready=1
//   throw_ready     high while idle
//   x_start         launch x, integer px (signed)
//   v0x, v0y        launch velocity, FRAC fractional bits (signed, +y = up)
//   x_pos, y_pos    projectile position in px (x signed, y = height, saturated)
//   visible         draw-stage enable
//   land_pulse      one-cycle pulse when the flight ends
//   land_oob        1 = last flight ended out of bounds, 0 = hit the ground
module projectile_sequencer #(
    parameter int unsigned FRAC        = 4,
    parameter int unsigned GRAVITY     = 16,
    parameter int unsigned X_LIMIT     = 527,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               throw_req,
    output logic               throw_ready,
    input  logic signed [11:0] x_start,
    input  logic signed [11:0] v0x,
    input  logic signed [11:0] v0y,
    output logic signed [11:0] x_pos,
    output logic        [11:0] y_pos,
    output logic               visible,
    output logic               land_pulse,
    output logic               land_oob
);

    localparam int unsigned W   = 12 + FRAC + 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW1 = CW + 1;

    localparam logic signed [W-1:0] XLIM = W'(X_LIMIT);
    localparam logic signed [W-1:0] GRAV = W'(GRAVITY);
    localparam logic signed [W-1:0] YMAX = W'(4095);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FLY  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                  vsync_d;
    logic                  tick;
    logic signed [11:0]    lx, lvx, lvy;
    logic signed [11:0]    lx_nxt, lvx_nxt, lvy_nxt;
    logic signed [W-1:0]   xa, ya, vx, vy;
    logic signed [W-1:0]   xa_nxt, ya_nxt, vx_nxt, vy_nxt;
    logic signed [W-1:0]   xn, yn, xs;
    logic        [CW-1:0]  cnt, cnt_nxt;
    logic                  visible_nxt, land_pulse_nxt, land_oob_nxt;
    logic                  hit_ground, out_of_bounds, hold_done;

    // Height in px, clamped to the 12-bit output range
    function automatic logic [11:0] y_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = v >>> FRAC;
        if (s[W-1])        return 12'd0;
        else if (s > YMAX) return 12'hfff;
        else               return 12'(s);
    endfunction

    // Frame tick: rising edge of vsync
    assign tick = vsync & ~vsync_d;

    // Candidate next position and the two end-of-flight conditions
    assign xn            = xa + vx;
    assign yn            = ya + vy;
    assign xs            = xn >>> FRAC;
    assign hit_ground    = yn[W-1] || (yn == '0);
    assign out_of_bounds = (xs > XLIM) || (xs < -XLIM);
    // Compare count+1 so HOLD_FRAMES=0 also exits on the first tick
    assign hold_done     = (({1'b0, cnt} + CW1'(1)) >= CW1'(HOLD_FRAMES));

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            vsync_d     <= 1'b0;
            lx          <= '0;
            lvx         <= '0;
            lvy         <= '0;
            xa          <= '0;
            ya          <= '0;
            vx          <= '0;
            vy          <= '0;
            cnt         <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            visible     <= 1'b0;
            land_pulse  <= 1'b0;
            land_oob    <= 1'b0;
            throw_ready <= 1'b1;
        end else begin
            state       <= state_nxt;
            vsync_d     <= vsync;
            lx          <= lx_nxt;
            lvx         <= lvx_nxt;
            lvy         <= lvy_nxt;
            xa          <= xa_nxt;
            ya          <= ya_nxt;
            vx          <= vx_nxt;
            vy          <= vy_nxt;
            cnt         <= cnt_nxt;
            x_pos       <= 12'(xa_nxt >>> FRAC);
            y_pos       <= y_sat(ya_nxt);
            visible     <= visible_nxt;
            land_pulse  <= land_pulse_nxt;
            land_oob    <= land_oob_nxt;
            throw_ready <= (state_nxt == IDLE);
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_nxt      = state;
        lx_nxt         = lx;
        lvx_nxt        = lvx;
        lvy_nxt        = lvy;
        xa_nxt         = xa;
        ya_nxt         = ya;
        vx_nxt         = vx;
        vy_nxt         = vy;
        cnt_nxt        = cnt;
        visible_nxt    = visible;
        land_pulse_nxt = 1'b0;
        land_oob_nxt   = land_oob;

        case (state)
            IDLE: begin
                if (throw_req) begin
                    lx_nxt    = x_start;
                    lvx_nxt   = v0x;
                    lvy_nxt   = v0y;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    xa_nxt      = W'(lx) <<< FRAC;
                    ya_nxt      = '0;
                    vx_nxt      = W'(lvx);
                    vy_nxt      = W'(lvy);
                    visible_nxt = 1'b1;
                    state_nxt   = FLY;
                end
            end
            FLY: begin
                if (tick) begin
                    vy_nxt = vy - GRAV;
                    xa_nxt = xn;
                    if (hit_ground) begin
                        ya_nxt         = '0;
                        land_oob_nxt   = 1'b0;
                        land_pulse_nxt = 1'b1;
                        cnt_nxt        = '0;
                        state_nxt      = HOLD;
                    end else begin
                        ya_nxt = yn;
                        if (out_of_bounds) begin
                            land_oob_nxt   = 1'b1;
                            land_pulse_nxt = 1'b1;
                            cnt_nxt        = '0;
                            state_nxt      = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_done) begin
                        visible_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_projectile_sequencer.sv
// Directed self-checking bench for projectile_sequencer.
module tb_projectile_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               vsync;
    logic               throw_req;
    logic               throw_ready;
    logic signed [11:0] x_start, v0x, v0y;
    logic signed [11:0] x_pos;
    logic        [11:0] y_pos;
    logic               visible, land_pulse, land_oob;

    int n_tests = 0;
    int n_fail  = 0;
    int lp_snap;

    projectile_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .throw_req   (throw_req),
        .throw_ready (throw_ready),
        .x_start     (x_start),
        .v0x         (v0x),
        .v0y         (v0y),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .visible     (visible),
        .land_pulse  (land_pulse),
        .land_oob    (land_oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One video frame: vsync high for 3 clks; land_pulse sampled just after the tick edge
    task automatic frame();
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        #1 lp_snap = int'(land_pulse);
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic throw(input int xs, input int vxi, input int vyi, input string tag);
        @(negedge clk);
        x_start   = 12'(xs);
        v0x       = 12'(vxi);
        v0y       = 12'(vyi);
        throw_req = 1'b1;
        @(posedge clk);
        #1 check({tag, " ready_fall"}, int'(throw_ready), 0);
        @(negedge clk) throw_req = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        x_start   = 12'sd300;
        v0x       = 12'sd80;
        v0y       = 12'sd200;
        throw_req = 1'b1;
        @(negedge clk) throw_req = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, " x"}, int'(x_pos), ex);
        check({tag, " y"}, int'(y_pos), ey);
    endtask

    // Wait out the hold period: still visible after 29 frames, gone after 30
    task automatic hold_out(input string tag);
        repeat (29) frame();
        check({tag, " vis_hold29"}, int'(visible), 1);
        frame();
        check({tag, " vis_hold30"}, int'(visible), 0);
        check({tag, " ready_back"}, int'(throw_ready), 1);
    endtask

    int ax[9] = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
    int ay[9] = '{4, 7, 9, 10, 10, 9, 7, 4, 0};

    initial begin
        rst = 1'b0; vsync = 1'b0; throw_req = 1'b0;
        x_start = '0; v0x = '0; v0y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_pos("rst", int'(x_pos), 0);
        check_pos("rst", 0, int'(y_pos));
        check("rst visible", int'(visible), 0);
        check("rst land_pulse", int'(land_pulse), 0);
        check("rst land_oob", int'(land_oob), 0);
        check("rst ready", int'(throw_ready), 1);
        @(negedge clk) rst = 1'b1;

        // Nominal arc
        throw(0, 32, 64, "nom");
        frame();
        check_pos("nom arm", 0, 0);
        check("nom arm vis", int'(visible), 1);
        for (int i = 0; i < 9; i++) begin
            frame();
            check_pos($sformatf("nom f%0d", i), ax[i], ay[i]);
            check($sformatf("nom lp f%0d", i), lp_snap, (i == 8) ? 1 : 0);
            if (i == 3) pulse_req();
        end
        check("nom oob", int'(land_oob), 0);
        check("nom lp_one_clk", int'(land_pulse), 0);
        pulse_req();
        hold_out("nom");
        check_pos("nom held", 18, 0);
        frame();
        frame();
        check("nom no_relaunch vis", int'(visible), 0);
        check_pos("nom no_relaunch", 18, 0);

        // Out of bounds on the first flight tick
        throw(520, 160, 320, "oob");
        frame();
        check_pos("oob arm", 520, 0);
        frame();
        check_pos("oob f0", 530, 20);
        check("oob lp", lp_snap, 1);
        check("oob flag", int'(land_oob), 1);
        hold_out("oob");

        // Ground-first launch, negative x and velocity
        throw(-100, -48, 0, "gnd");
        frame();
        check_pos("gnd arm", -100, 0);
        frame();
        check_pos("gnd f0", -103, 0);
        check("gnd lp", lp_snap, 1);
        check("gnd oob", int'(land_oob), 0);
        hold_out("gnd");

        // throw_req coincident with a tick in IDLE: that tick is not used
        @(negedge clk);
        x_start = 12'sd100; v0x = 12'sd16; v0y = 12'sd64;
        throw_req = 1'b1; vsync = 1'b1;
        @(negedge clk) throw_req = 1'b0;
        @(negedge clk) vsync = 1'b0;
        repeat (2) @(negedge clk);
        check("sim ready", int'(throw_ready), 0);
        check("sim vis", int'(visible), 0);
        check_pos("sim hold", -103, 0);
        frame();
        check_pos("sim arm", 100, 0);
        frame();
        check_pos("sim f0", 101, 4);

        // Reset mid-flight
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check_pos("mrst", 0, 0);
        check("mrst vis", int'(visible), 0);
        check("mrst lp", int'(land_pulse), 0);
        check("mrst oob", int'(land_oob), 0);
        check("mrst ready", int'(throw_ready), 1);
        @(negedge clk) rst = 1'b1;
        frame();
        check("mrst after lp", lp_snap, 0);
        check("mrst after vis", int'(visible), 0);
        check_pos("mrst after", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
